// File: rtl/led_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// led_frame_scheduler_if
// Pixel-write bus and swap handshake between the game logic (master) and the
// LED frame scheduler (slave).
//   wr_en        master->slave  write one pixel into the back buffer
//   wr_x, wr_y   master->slave  pixel column / row
//   wr_color     master->slave  bit0 = red, bit1 = green (00 = off)
//   clr          master->slave  clear the whole back buffer
//   swap_req     master->slave  request a front/back swap at the next frame
//   swap_pending slave->master  swap requested, not yet taken
//   swap_ack     slave->master  one-cycle pulse after a swap is taken
// -----------------------------------------------------------------------------
interface led_frame_scheduler_if;
   logic       wr_en;
   logic [2:0] wr_x;
   logic [2:0] wr_y;
   logic [1:0] wr_color;
   logic       clr;
   logic       swap_req;
   logic       swap_pending;
   logic       swap_ack;

   modport master (
      output wr_en, wr_x, wr_y, wr_color, clr, swap_req,
      input  swap_pending, swap_ack
   );

   modport slave (
      input  wr_en, wr_x, wr_y, wr_color, clr, swap_req,
      output swap_pending, swap_ack
   );
endinterface

// File: rtl/led_frame_scheduler.sv
// -----------------------------------------------------------------------------
// led_frame_scheduler
// Double-buffered frame store and row scanner for an 8x8 red/green LED matrix.
// Game logic writes the back buffer; the front buffer is scanned one row per
// ROW_DIV cycles. Swaps are deferred to the frame boundary so the picture
// never tears, and the first BLANK cycles of every row are blanked.
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   bus           pixel-write / swap handshake (slave side)
//   frame_start   one-cycle pulse after the row index wraps 7 -> 0
//   red_driver    red column drive, active-high
//   green_driver  green column drive, active-high
//   row_sink      active-low one-hot row select, 8'hFF while blanked
// -----------------------------------------------------------------------------
module led_frame_scheduler #(
   parameter int unsigned ROW_DIV = 1000,
   parameter int unsigned BLANK   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   led_frame_scheduler_if.slave  bus,
   output logic                  frame_start,
   output logic [7:0]            red_driver,
   output logic [7:0]            green_driver,
   output logic [7:0]            row_sink
);

   localparam logic [15:0] DIV_MAX = 16'(ROW_DIV - 1);

   logic [15:0] div_cnt;
   logic [2:0]  row;
   logic        sel;
   logic        swap_pending_q;
   logic        swap_ack_q;
   logic        frame_start_q;

   // [buffer][row] -> column bits
   logic [7:0]  red_buf   [0:1][0:7];
   logic [7:0]  green_buf [0:1][0:7];

   logic        row_tick;
   logic        frame_boundary;
   logic        take_swap;
   logic        back;
   logic        blank;

   assign row_tick       = (div_cnt == DIV_MAX);
   assign frame_boundary = row_tick && (row == 3'd7);
   // A request arriving in the boundary cycle itself is taken immediately.
   assign take_swap      = frame_boundary && (swap_pending_q || bus.swap_req);
   assign back           = ~sel;

   // Prescaler, row counter and swap handshake
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt        <= '0;
         row            <= '0;
         sel            <= 1'b0;
         swap_pending_q <= 1'b0;
         swap_ack_q     <= 1'b0;
         frame_start_q  <= 1'b0;
      end else begin
         div_cnt       <= row_tick ? '0 : div_cnt + 16'd1;
         if (row_tick)
            row <= row + 3'd1;
         frame_start_q <= frame_boundary;
         swap_ack_q    <= take_swap;
         if (take_swap) begin
            sel            <= ~sel;
            swap_pending_q <= 1'b0;
         end else if (bus.swap_req) begin
            swap_pending_q <= 1'b1;
         end
      end
   end

   // Back-buffer writes. The pixel write follows the clear so that, when both
   // occur together, the later assignment leaves the written pixel intact.
   // Writes in a swap cycle still hit the pre-swap back buffer (old sel).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned y = 0; y < 8; y++) begin
               red_buf[b][y]   <= '0;
               green_buf[b][y] <= '0;
            end
         end
      end else begin
         if (bus.clr) begin
            for (int unsigned y = 0; y < 8; y++) begin
               red_buf[back][y]   <= '0;
               green_buf[back][y] <= '0;
            end
         end
         if (bus.wr_en) begin
            red_buf[back][bus.wr_y][bus.wr_x]   <= bus.wr_color[0];
            green_buf[back][bus.wr_y][bus.wr_x] <= bus.wr_color[1];
         end
      end
   end

   generate
      if (BLANK != 0) begin : g_blank
         assign blank = (div_cnt < 16'(BLANK));
      end else begin : g_no_blank
         assign blank = 1'b0;
      end
   endgenerate

   // Display decode from registered state only
   always_comb begin
      row_sink     = 8'hFF;
      red_driver   = '0;
      green_driver = '0;
      if (!blank) begin
         row_sink     = ~(8'h01 << row);
         red_driver   = red_buf[sel][row];
         green_driver = green_buf[sel][row];
      end
   end

   assign frame_start      = frame_start_q;
   assign bus.swap_pending = swap_pending_q;
   assign bus.swap_ack     = swap_ack_q;

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Double-buffered frame controller and row scheduler for the 8x8 red/green LED matrix. Game logic draws pixels into a back buffer while the front buffer is row-scanned onto the matrix pins. A requested buffer swap is deferred to the next frame boundary, so the display never tears. The block also blanks the matrix briefly at the start of each row to suppress ghosting.

Parameters:
ROW_DIV, 1000, clock cycles per displayed row; legal range 2..65535.
BLANK, 4, cycles at the start of each row with all rows off; legal range 0..ROW_DIV-1.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write one pixel into the back buffer this cycle
wr_x  in  3  pixel column; selects the driver bit
wr_y  in  3  pixel row
wr_color  in  2  bit0 = red, bit1 = green; 2'b00 turns the pixel off
clr  in  1  clear the entire back buffer this cycle
swap_req  in  1  request a front/back swap; sampled every cycle
swap_pending  out  1  a swap has been requested and not yet taken
swap_ack  out  1  one-cycle pulse in the cycle after a swap is taken
frame_start  out  1  one-cycle pulse in the cycle after the row index wraps from 7 to 0
red_driver  out  8  red column drive, active-high
green_driver  out  8  green column drive, active-high
row_sink  out  8  row select, active-low one-hot; 8'hFF when blanked

Behaviour:
- Reset is asynchronous on reset_n low. It clears div_cnt, row, sel, swap_pending, swap_ack, frame_start and both buffers (2 buffers x 2 colours x 8x8).
  - After reset: drivers = 8'h00; row_sink = 8'hFF if BLANK > 0, else 8'hFE.
  - Reset asserted mid-frame forces these values immediately, without waiting for a clock edge.
- Prescaler:
  - div_cnt counts 0..ROW_DIV-1 and then wraps to 0.
  - row_tick is asserted when div_cnt == ROW_DIV-1.
- Row counter:
  - row (3 bits) increments on row_tick and wraps from 7 to 0.
  - frame_boundary = row_tick && row == 7.
- Display outputs are combinational decodes of registered state:
  - blank = (div_cnt < BLANK).
  - When blank: row_sink = 8'hFF and both drivers = 8'h00.
  - Otherwise: row_sink = ~(8'h01 << row), red_driver = front_red[row], green_driver = front_green[row].
- Buffers:
  - sel selects the front buffer; the back buffer is !sel.
  - A pointer swap toggles sel. After a swap, the new back buffer holds the previously displayed frame and is not cleared.
- Writes:
  - On a clock edge with wr_en: back_red[wr_y][wr_x] <= wr_color[0] and back_green[wr_y][wr_x] <= wr_color[1].
  - clr zeroes both back-buffer planes.
  - clr and wr_en in the same cycle: the clear applies, then the write; the written pixel holds wr_color and all others are 0.
  - The front buffer is never writable.
- Swap handshake:
  - swap_pending is set on any cycle with swap_req high. A repeat request while pending is absorbed.
  - On frame_boundary with (swap_pending || swap_req): sel toggles, swap_pending clears, swap_ack pulses in the next cycle.
  - swap_req in the same cycle as frame_boundary is taken at that boundary.
  - A write or clr in the swap cycle targets the pre-swap back buffer. That buffer becomes front, so the write is visible in the new frame.
  - Writes while pending are allowed; they land in the back buffer before the swap.
- frame_start pulses in the cycle after every frame_boundary, whether or not a swap is taken.
- Frame period is 8*ROW_DIV cycles. Latency from a swap being taken to the new data on the drivers is BLANK cycles (the row-0 blank window).

Test Plan:
(ROW_DIV=8, BLANK=2 for all scenarios.)
- Reset, then free-run:
  - Cycles 0-1: row_sink = FF.
  - Cycles 2-7: row_sink = FE.
  - Cycles 10-15: row_sink = FD.
  - Continues through 7F, then row_sink = FE again at cycle 66.
  - frame_start is high at cycle 64 only.
- Deferred swap:
  - Stimulus: write (x=3, y=0, colour 01) and swap_req at cycle 5.
  - swap_pending is high from cycle 6 to 63.
  - red_driver stays 00 until the boundary; swap_ack is high at cycle 64.
  - Cycles 66-71: red_driver = 08; green_driver = 00.
- clr with wr_en in the same cycle:
  - Stimulus: back buffer prefilled with all ones; in one cycle clr=1 and wr (x=7, y=2, colour 10); then swap.
  - In row 2 after the swap: green_driver = 80, red_driver = 00.
  - All other rows: 00.
- Write in the boundary cycle:
  - Stimulus: swap_req and wr (x=0, y=1, colour 11) both in cycle 63.
  - Swap is taken at cycle 63 (swap_ack at 64).
  - Cycles 74-79: both drivers = 01.
- Pointer swap without redraw:
  - Two consecutive swaps with no writes: the first frame's content reappears after the second swap, and swap_ack fires once per swap.
- Asynchronous reset:
  - Stimulus: reset_n low mid-row with a non-zero frame displayed.
  - Same cycle, before the next edge: row_sink = FF and drivers = 00.
  - After release: both buffers read 00 and swap_pending = 0.
